// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame geometry and timer widths.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int TIMER_W   = 11;  // holds a bit period of up to 1025 clocks
    localparam int CPD_W     = 10;
    localparam int IDX_W     = 3;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the asynchronous serial line; resets to the idle level.
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // NOTE: flip-flops take non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sync_q <= '1;
        else         sync_q <= {sync_q[STAGES-2:0], d};
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ack byte delivery, overrun and framing-error reporting.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority sampling around each sample point.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = uart_pkg::DATA_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [CPD_W-1:0]     cycles_per_databit,
    input  logic                 rx_line,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_overrun,
    output logic                 framing_error,
    output logic                 rx_busy
);

    rx_state_e            state, next_state;
    logic [TIMER_W-1:0]   timer;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_q;
    logic [TIMER_W-1:0]   period, half, start_pt;
    logic                 rx_s, bit_smp, at_point;
    logic                 timer_clr, take_bit, deliver, frame_err;

    uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (rx_line),
        .q      (rx_s)
    );

    assign period = {1'b0, cycles_per_databit} + TIMER_W'(2);
    assign half   = period >> 1;

`ifdef UART_RX_MAJORITY_EN
    logic rx_d1, rx_d2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_d1 <= IDLE_LEVEL;
            rx_d2 <= IDLE_LEVEL;
        end else begin
            rx_d1 <= rx_s;
            rx_d2 <= rx_d1;
        end
    end

    // Decision one clock late so the window straddles the nominal point; later bits inherit the shift.
    assign bit_smp  = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
    assign start_pt = half;
`else
    assign bit_smp  = rx_s;
    assign start_pt = half - TIMER_W'(1);
`endif

    assign at_point = (timer == ((state == ST_START) ? start_pt : period - TIMER_W'(1)));
    assign rx_busy  = (state != ST_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= next_state;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        timer_clr  = 1'b0;
        take_bit   = 1'b0;
        deliver    = 1'b0;
        frame_err  = 1'b0;
        case (state)
            ST_IDLE:  if (rx_s == START_BIT) next_state = ST_START;
            ST_START: if (at_point) next_state = (bit_smp == START_BIT) ? ST_DATA : ST_IDLE;
            ST_DATA: begin
                if (at_point) begin
                    take_bit  = 1'b1;
                    timer_clr = 1'b1;
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (at_point) begin
                    if (bit_smp == STOP_BIT) begin
                        deliver    = 1'b1;
                        next_state = ST_IDLE;
                    end else begin
                        frame_err  = 1'b1;
                        next_state = ST_BREAK;
                    end
                end
            end
            ST_BREAK: if (rx_s == IDLE_LEVEL) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer   <= '0;
            bit_idx <= '0;
            shift_q <= '0;
        end else begin
            if (next_state != state || timer_clr)
                timer <= '0;
            else if (state == ST_START || state == ST_DATA || state == ST_STOP)
                timer <= timer + TIMER_W'(1);

            if (next_state == ST_DATA && state != ST_DATA)
                bit_idx <= '0;
            else if (take_bit)
                bit_idx <= bit_idx + IDX_W'(1);

            if (take_bit) shift_q[bit_idx] <= bit_smp;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_overrun    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            framing_error <= frame_err;
            if (deliver) begin
                // A same-cycle ack consumed the old byte, so that case is not an overrun.
                rx_data    <= shift_q;
                rx_valid   <= 1'b1;
                rx_overrun <= rx_valid & ~rx_ack;
            end else if (rx_ack && rx_valid) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
        end
    end

endmodule
